irrq_ctrl: RTL

IRRQ_CTRL -- requirements
Module: irrq_ctrl

---
 rtl/irrq_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/irrq_ctrl.sv
// Read-request queue and response segmenter: buffers incoming read requests in a
// circular FIFO and splits each one into MAX_SEG-sized response segment headers.
module irrq_ctrl #(
    parameter int DEPTH   = 8,
    parameter int MAX_SEG = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    input  logic [47:0] reqInfo,
    output logic        respValid,
    input  logic        respReady,
    output logic [7:0]  respTag,
    output logic [7:0]  respQueue,
    output logic [15:0] respAddr,
    output logic [8:0]  respLen,
    output logic        respLast,
    output logic        reqDrop,
    output logic [7:0]  dropCnt,
    output logic [4:0]  queueLevel,
    output logic        busy
);

    localparam int          PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] SEG      = 17'(MAX_SEG);
    localparam logic [15:0] SEG_STEP = 16'(MAX_SEG);
    localparam logic [4:0]  LVL_FULL = 5'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [47:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [4:0]         level;
    logic [15:0]        remaining;

    logic [47:0]        head;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               drop;
    logic               hs;
    logic [15:0]        rem_next;

    function automatic logic [8:0] seg_len(input logic [15:0] rem);
        if ({1'b0, rem} > SEG) return 9'(MAX_SEG);
        return rem[8:0];
    endfunction

    function automatic logic seg_last(input logic [15:0] rem);
        return ({1'b0, rem} <= SEG);
    endfunction

    assign head       = mem[rd_ptr];
    assign full       = (level == LVL_FULL);
    assign empty      = (level == 5'd0);
    // The FSM only pulls a new request while idle, so a pop frees a slot the same cycle.
    assign pop        = (state == IDLE) && !empty;
    assign push       = reqValid && (!full || pop);
    assign drop       = reqValid && full && !pop;
    assign hs         = respValid && respReady;
    assign rem_next   = remaining - SEG_STEP;
    assign queueLevel = level;

    // Storage needs no reset; only the pointers and level define valid contents.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= reqInfo;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            reqDrop <= 1'b0;
            dropCnt <= '0;
        end else begin
            reqDrop <= drop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + 5'd1;
                2'b01:   level <= level - 5'd1;
                default: level <= level;
            endcase
            if (drop && dropCnt != 8'hFF) dropCnt <= dropCnt + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            respValid <= 1'b0;
            respTag   <= '0;
            respQueue <= '0;
            respAddr  <= '0;
            respLen   <= '0;
            respLast  <= 1'b0;
            remaining <= '0;
        end else if (state == IDLE) begin
            if (pop) begin
                state     <= SEND;
                busy      <= 1'b1;
                respValid <= 1'b1;
                respTag   <= head[47:40];
                respQueue <= head[39:32];
                respAddr  <= head[31:16];
                remaining <= head[15:0];
                respLen   <= seg_len(head[15:0]);
                respLast  <= seg_last(head[15:0]);
            end
        end else if (hs) begin
            if (respLast) begin
                state     <= IDLE;
                busy      <= 1'b0;
                respValid <= 1'b0;
                respLast  <= 1'b0;
            end else begin
                // Next segment is prepared on the accepting edge, so segments stream back to back.
                respAddr  <= respAddr + SEG_STEP;
                remaining <= rem_next;
                respLen   <= seg_len(rem_next);
                respLast  <= seg_last(rem_next);
            end
        end
    end

endmodule
